// File: rtl/spi_accel_pkg.sv
// Shared constants and types for the accelerometer SPI responder.
package spi_accel_pkg;

   // Register map
   localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
   localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
   localparam logic [5:0] ADDR_INT2_CFG  = 6'h25;
   localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
   localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;

   // Bit positions inside the command byte (frame bits 15:8)
   localparam int unsigned BIT_RW   = 7;
   localparam int unsigned BIT_MS   = 6;
   localparam int unsigned ADDR_MSB = 5;

   // Responder frame FSM
   typedef enum logic [1:0] {
      ARM,
      IDLE,
      CMD,
      DATA
   } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with rise/fall pulse outputs.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Synchronise the pin and keep the previous synchronised value for edge detection
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-3 responder modelling the accelerometer register interface.
module spi_accel_responder
   import spi_accel_pkg::*;
#(
   parameter logic [7:0] WHO_AM_I_VAL  = 8'h33,
   parameter logic [7:0] CTRL_REG1_RST = 8'h07,
   parameter logic [7:0] INT2_CFG_RST  = 8'h00
) (
   input  logic        CLK_50,
   input  logic        RESET,
   input  logic        CS,
   input  logic        SCLK,
   input  logic        DIN,
   output logic        DO,
   output logic        DO_OE,
   input  logic [15:0] X_SAMPLE,
   input  logic        X_VALID,
   output logic [7:0]  CTRL_REG1,
   output logic [7:0]  INT2_CFG,
   output logic        WR_STB,
   output logic [5:0]  WR_ADDR,
   output logic        FRAME_ERR
);

   logic w_cs_lvl, w_cs_rise, w_cs_fall;
   logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
   logic w_din_lvl, w_din_rise, w_din_fall;
   logic w_unused;

   state_t r_state, w_state_d;

   logic [2:0]  r_bit_cnt;
   logic [6:0]  r_shift_in;
   logic        r_rw;
   logic        r_ms;
   logic [5:0]  r_addr;
   logic [7:0]  r_do_shift;
   logic        r_do;
   logic        r_do_oe;
   logic        r_fetch;
   logic        r_byte_done;
   logic [7:0]  r_wdata;
   logic [7:0]  r_ctrl;
   logic [7:0]  r_int2;
   logic [15:0] r_out_x;
   logic [15:0] r_pend_x;
   logic        r_pend_v;
   logic        r_wr_stb;
   logic [5:0]  r_wr_addr;
   logic        r_frame_err;

   logic        w_in_frame;
   logic        w_shift;
   logic        w_byte_end;
   logic        w_cmd_end;
   logic        w_abort;
   logic [7:0]  w_byte;
   logic [7:0]  w_rd_data;

   // CS resets low so that a frame in flight at reset is not mistaken for a new one
   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
      .i_clk   (CLK_50),
      .i_rst   (RESET),
      .i_async (CS),
      .o_level (w_cs_lvl),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   // SCLK idles high
   spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
      .i_clk   (CLK_50),
      .i_rst   (RESET),
      .i_async (SCLK),
      .o_level (w_sclk_lvl),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sync_din (
      .i_clk   (CLK_50),
      .i_rst   (RESET),
      .i_async (DIN),
      .o_level (w_din_lvl),
      .o_rise  (w_din_rise),
      .o_fall  (w_din_fall)
   );

   assign w_unused = w_sclk_lvl ^ w_din_rise ^ w_din_fall;

   assign w_in_frame = (r_state == CMD) || (r_state == DATA);
   assign w_shift    = w_in_frame && w_sclk_rise;
   assign w_byte_end = w_shift && (r_bit_cnt == 3'd7);
   assign w_cmd_end  = w_byte_end && (r_state == CMD);
   assign w_abort    = w_in_frame && w_cs_rise;
   assign w_byte     = {r_shift_in, w_din_lvl};

   // Register read mux, addressed by the current frame address
   always_comb begin
      w_rd_data = 8'h00;
      case (r_addr)
         ADDR_WHO_AM_I:  w_rd_data = WHO_AM_I_VAL;
         ADDR_CTRL_REG1: w_rd_data = r_ctrl;
         ADDR_INT2_CFG:  w_rd_data = r_int2;
         ADDR_OUT_X_L:   w_rd_data = r_out_x[7:0];
         ADDR_OUT_X_H:   w_rd_data = r_out_x[15:8];
         default:        w_rd_data = 8'h00;
      endcase
   end

   // FSM state register
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_state <= ARM;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ARM:     if (w_cs_lvl) w_state_d = IDLE;
         IDLE:    if (w_cs_fall) w_state_d = CMD;
         CMD: begin
            if (w_cs_rise) begin
               w_state_d = IDLE;
            end else if (w_byte_end) begin
               w_state_d = DATA;
            end
         end
         DATA:    if (w_cs_rise) w_state_d = IDLE;
         default: w_state_d = ARM;
      endcase
   end

   // Frame datapath: shift-in, DO shifter, write commit and error flag
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_bit_cnt   <= 3'd0;
         r_shift_in  <= 7'd0;
         r_rw        <= 1'b0;
         r_ms        <= 1'b0;
         r_addr      <= 6'd0;
         r_do_shift  <= 8'h00;
         r_do        <= 1'b0;
         r_do_oe     <= 1'b0;
         r_fetch     <= 1'b0;
         r_byte_done <= 1'b0;
         r_wdata     <= 8'h00;
         r_ctrl      <= CTRL_REG1_RST;
         r_int2      <= INT2_CFG_RST;
         r_wr_stb    <= 1'b0;
         r_wr_addr   <= 6'd0;
         r_frame_err <= 1'b0;
      end else begin
         r_do_oe     <= ~w_cs_lvl;
         r_wr_stb    <= 1'b0;
         r_fetch     <= 1'b0;
         r_byte_done <= 1'b0;

         if (!w_in_frame || w_abort) begin
            r_bit_cnt <= 3'd0;
         end else if (w_shift) begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_shift_in <= w_byte[6:0];
         end

         // A partial byte at CS rise is dropped; only the error is recorded
         if (w_abort && (r_bit_cnt != 3'd0)) begin
            r_frame_err <= 1'b1;
         end

         if (w_cmd_end && !w_abort) begin
            r_rw    <= w_byte[BIT_RW];
            r_ms    <= w_byte[BIT_MS];
            r_addr  <= w_byte[ADDR_MSB:0];
            r_fetch <= w_byte[BIT_RW];
         end

         if (w_byte_end && (r_state == DATA) && !w_abort) begin
            r_byte_done <= 1'b1;
            r_wdata     <= w_byte;
         end

         // Commit the finished byte, then step the address for the next one
         if (r_byte_done) begin
            if (!r_rw) begin
               case (r_addr)
                  ADDR_CTRL_REG1: begin
                     r_ctrl    <= r_wdata;
                     r_wr_stb  <= 1'b1;
                     r_wr_addr <= r_addr;
                  end
                  ADDR_INT2_CFG: begin
                     r_int2    <= r_wdata;
                     r_wr_stb  <= 1'b1;
                     r_wr_addr <= r_addr;
                  end
                  default: ;
               endcase
            end
            if (r_ms) begin
               r_addr <= r_addr + 6'd1;
            end
            r_fetch <= r_rw;
         end

         if (r_fetch) begin
            r_do_shift <= w_rd_data;
         end else if ((r_state == DATA) && r_rw && w_sclk_fall) begin
            r_do       <= r_do_shift[7];
            r_do_shift <= {r_do_shift[6:0], 1'b0};
         end

         if (r_state != DATA) begin
            r_do <= 1'b0;
         end
      end
   end

   // OUT_X update; samples arriving mid-frame wait until CS is high again
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_out_x  <= 16'h0000;
         r_pend_x <= 16'h0000;
         r_pend_v <= 1'b0;
      end else if (X_VALID && w_cs_lvl) begin
         r_out_x  <= X_SAMPLE;
         r_pend_v <= 1'b0;
      end else if (X_VALID) begin
         r_pend_x <= X_SAMPLE;
         r_pend_v <= 1'b1;
      end else if (r_pend_v && w_cs_lvl) begin
         r_out_x  <= r_pend_x;
         r_pend_v <= 1'b0;
      end
   end

   assign DO        = r_do;
   assign DO_OE     = r_do_oe;
   assign CTRL_REG1 = r_ctrl;
   assign INT2_CFG  = r_int2;
   assign WR_STB    = r_wr_stb;
   assign WR_ADDR   = r_wr_addr;
   assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Scoreboard bench for spi_accel_responder: randomized SPI frames against a register-map model.
`timescale 1ns/1ps
module tb_spi_accel_responder;

   localparam int H = 8;  // SCLK half period in CLK_50 cycles

   logic        CLK_50 = 1'b0;
   logic        RESET = 1'b1;
   logic        CS = 1'b1;
   logic        SCLK = 1'b1;
   logic        DIN = 1'b0;
   logic [15:0] X_SAMPLE = 16'h0000;
   logic        X_VALID = 1'b0;
   logic        DO, DO_OE, WR_STB, FRAME_ERR;
   logic [7:0]  CTRL_REG1, INT2_CFG;
   logic [5:0]  WR_ADDR;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  q_rd[$];
   logic [13:0] q_wr[$];

   // Register-map model
   logic [7:0]  m_ctrl = 8'h07;
   logic [7:0]  m_int2 = 8'h00;
   logic [15:0] m_outx = 16'h0000;
   logic [15:0] m_pend = 16'h0000;
   bit          m_pend_v = 1'b0;
   bit          m_ferr = 1'b0;
   bit          in_frame = 1'b0;

   spi_accel_responder u_dut (
      .CLK_50    (CLK_50),
      .RESET     (RESET),
      .CS        (CS),
      .SCLK      (SCLK),
      .DIN       (DIN),
      .DO        (DO),
      .DO_OE     (DO_OE),
      .X_SAMPLE  (X_SAMPLE),
      .X_VALID   (X_VALID),
      .CTRL_REG1 (CTRL_REG1),
      .INT2_CFG  (INT2_CFG),
      .WR_STB    (WR_STB),
      .WR_ADDR   (WR_ADDR),
      .FRAME_ERR (FRAME_ERR)
   );

   always #10 CLK_50 = ~CLK_50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge CLK_50);
   endtask

   function automatic logic [7:0] m_read(input logic [5:0] a);
      case (a)
         6'h0F:   return 8'h33;
         6'h20:   return m_ctrl;
         6'h25:   return m_int2;
         6'h28:   return m_outx[7:0];
         6'h29:   return m_outx[15:8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_write(input logic [5:0] a, input logic [7:0] d);
      if (a == 6'h20) begin
         m_ctrl = d;
         q_wr.push_back({a, d});
      end else if (a == 6'h25) begin
         m_int2 = d;
         q_wr.push_back({a, d});
      end
   endtask

   task automatic reset_model();
      m_ctrl = 8'h07;
      m_int2 = 8'h00;
      m_outx = 16'h0000;
      m_pend_v = 1'b0;
      m_ferr = 1'b0;
   endtask

   // Expected DO bytes and register writes for a frame of nbits (left-aligned in tx)
   task automatic model_frame(input logic [31:0] tx, input int nbits);
      logic [5:0] a;
      logic [7:0] d;
      a = tx[29:24];
      for (int i = 1; i < nbits / 8; i++) begin
         d = tx[31 - 8 * i -: 8];
         if (tx[31]) begin
            q_rd.push_back(m_read(a));
         end else begin
            q_rd.push_back(8'h00);
            m_write(a, d);
         end
         if (tx[30]) a = a + 6'd1;
      end
      if (nbits % 8 != 0) m_ferr = 1'b1;
   endtask

   // SPI mode-3 master: DIN changes with SCLK falling, responder samples on rising
   task automatic spi_frame(input logic [31:0] tx, input int nbits);
      in_frame = 1'b1;
      CS = 1'b0;
      wait_clk(H);
      for (int k = 0; k < nbits; k++) begin
         SCLK = 1'b0;
         DIN = tx[31 - k];
         wait_clk(H);
         SCLK = 1'b1;
         wait_clk(H);
      end
      CS = 1'b1;
      wait_clk(12);
      in_frame = 1'b0;
      if (m_pend_v) begin
         m_outx = m_pend;
         m_pend_v = 1'b0;
      end
   endtask

   task automatic x_pulse(input logic [15:0] v);
      X_SAMPLE = v;
      X_VALID = 1'b1;
      if (in_frame) begin
         m_pend = v;
         m_pend_v = 1'b1;
      end else begin
         m_outx = v;
      end
      wait_clk(1);
      X_VALID = 1'b0;
   endtask

   task automatic run_frame(input logic [31:0] tx, input int nbits, input bit mid_x,
                            input logic [15:0] xv);
      model_frame(tx, nbits);
      fork
         spi_frame(tx, nbits);
         begin
            if (mid_x) begin
               wait_clk(3 * H);
               x_pulse(xv);
            end
         end
      join
   endtask

   // Monitor: collect DO bits on SCLK rising edges and compare each whole byte
   initial begin : rx_monitor
      int         nb;
      logic [7:0] sh;
      sh = 8'h00;
      forever begin
         @(negedge CS);
         nb = 0;
         while (CS == 1'b0) begin
            @(posedge SCLK or posedge CS);
            if (CS == 1'b0) begin
               sh = {sh[6:0], DO};
               nb++;
               if (nb % 8 == 0) begin
                  if (nb == 8) begin
                     check("do_cmd_byte", {24'd0, sh}, 32'd0);
                  end else if (q_rd.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL rd_byte: got %h with no byte expected", sh);
                  end else begin
                     check("rd_byte", {24'd0, sh}, {24'd0, q_rd.pop_front()});
                  end
               end
            end
         end
      end
   end

   // Monitor: every WR_STB must match the next expected write
   initial begin : wr_monitor
      logic [13:0] e;
      forever begin
         @(negedge CLK_50);
         if (WR_STB === 1'b1) begin
            if (q_wr.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL wr_stb: unexpected strobe addr %h", WR_ADDR);
            end else begin
               e = q_wr.pop_front();
               check("wr_addr", {26'd0, WR_ADDR}, {26'd0, e[13:8]});
               if (e[13:8] == 6'h20) check("wr_ctrl", {24'd0, CTRL_REG1}, {24'd0, e[7:0]});
               else check("wr_int2", {24'd0, INT2_CFG}, {24'd0, e[7:0]});
            end
         end
      end
   end

   initial begin : watchdog
      #1_800_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [31:0] tx;
      logic [5:0]  a;
      int          nb, nbits;
      bit          mid;

      // Reset state
      wait_clk(4);
      check("rst_do", {31'd0, DO}, 32'd0);
      check("rst_do_oe", {31'd0, DO_OE}, 32'd0);
      check("rst_ctrl", {24'd0, CTRL_REG1}, 32'h07);
      check("rst_int2", {24'd0, INT2_CFG}, 32'h00);
      check("rst_wr_stb", {31'd0, WR_STB}, 32'd0);
      check("rst_wr_addr", {26'd0, WR_ADDR}, 32'd0);
      check("rst_frame_err", {31'd0, FRAME_ERR}, 32'd0);
      RESET = 1'b0;
      wait_clk(10);

      // WHO_AM_I read and the two writable registers
      run_frame(32'h8F00_0000, 16, 1'b0, 16'h0);
      check("ctrl_after_read", {24'd0, CTRL_REG1}, 32'h07);
      run_frame(32'h2087_0000, 16, 1'b0, 16'h0);
      check("ctrl_write", {24'd0, CTRL_REG1}, 32'h87);
      check("wr_addr_last", {26'd0, WR_ADDR}, 32'h20);
      run_frame(32'h253F_0000, 16, 1'b0, 16'h0);
      check("int2_write", {24'd0, INT2_CFG}, 32'h3F);

      // OUT_X from an idle sample
      x_pulse(16'hFEDC);
      wait_clk(4);
      run_frame(32'hA800_0000, 16, 1'b0, 16'h0);
      run_frame(32'hA900_0000, 16, 1'b0, 16'h0);

      // Auto-increment read, new sample mid-frame must not split the pair
      x_pulse(16'h1234);
      wait_clk(4);
      run_frame(32'hE800_0000, 24, 1'b1, 16'hABCD);
      run_frame(32'hA800_0000, 16, 1'b0, 16'h0);
      run_frame(32'hA900_0000, 16, 1'b0, 16'h0);

      // CS rises mid-byte: partial write dropped, error flagged
      run_frame(32'h2055_0000, 11, 1'b0, 16'h0);
      check("abort_ctrl", {24'd0, CTRL_REG1}, 32'h87);
      check("abort_ferr", {31'd0, FRAME_ERR}, 32'd1);
      run_frame(32'hA000_0000, 16, 1'b0, 16'h0);

      // RESET mid-frame with CS held low; rest of that frame is ignored
      q_rd.push_back(8'h00);
      fork
         spi_frame(32'h2011_0000, 16);
         begin
            wait_clk(11 * H);
            RESET = 1'b1;
            wait_clk(3);
            RESET = 1'b0;
            reset_model();
         end
      join
      check("rstmid_ctrl", {24'd0, CTRL_REG1}, 32'h07);
      check("rstmid_ferr", {31'd0, FRAME_ERR}, 32'd0);
      run_frame(32'h0F55_0000, 16, 1'b0, 16'h0);
      run_frame(32'h8F00_0000, 16, 1'b0, 16'h0);

      // Randomized frames
      for (int f = 0; f < 40; f++) begin
         case ($urandom_range(0, 6))
            0:       a = 6'h0F;
            1:       a = 6'h20;
            2:       a = 6'h25;
            3:       a = 6'h28;
            4:       a = 6'h29;
            5:       a = 6'h3F;
            default: a = 6'($urandom_range(0, 63));
         endcase
         tx = $urandom;
         tx[29:24] = a;
         nb = $urandom_range(1, 3);
         if ($urandom_range(0, 5) == 0) nbits = 8 * $urandom_range(0, nb) + $urandom_range(1, 7);
         else nbits = 8 * (nb + 1);
         mid = (nbits >= 4) && ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) == 0) begin
            x_pulse(16'($urandom));
            wait_clk(4);
         end
         run_frame(tx, nbits, mid, 16'($urandom));
      end

      wait_clk(20);
      check("rd_queue_empty", q_rd.size(), 32'd0);
      check("wr_queue_empty", q_wr.size(), 32'd0);
      check("final_ctrl", {24'd0, CTRL_REG1}, {24'd0, m_ctrl});
      check("final_int2", {24'd0, INT2_CFG}, {24'd0, m_int2});
      check("final_ferr", {31'd0, FRAME_ERR}, {31'd0, m_ferr});
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
